param_register_file: RTL and testbench

- Parametrised successor to the CPU's single-write, two-read register file.
- Width, depth and read/write port counts are configurable.
- Adds a same-cycle write-to-read bypass, a per-entry pending scoreboard for hazard tracking, and a multi-cycle clear sequencer.
- Sits in the decode stage of each core; scoreboard outputs feed the hazard unit.

---
 rtl/param_register_file.sv | 143 ++++++++++++++
 tb/tb_param_register_file.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - multi-port register file with write bypass, pending scoreboard and clear sequencer
// Entry 0 may be hardwired to zero; CLEAR zeroes one entry per cycle while reads stay live.
module param_register_file #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     clear,
  output logic                     busy,
  input  logic [NWRITE-1:0]        wen,
  input  logic [NWRITE*ADDR_W-1:0] wsel,
  input  logic [NWRITE*DATA_W-1:0] wdat,
  input  logic [NREAD*ADDR_W-1:0]  rsel,
  output logic [NREAD*DATA_W-1:0]  rdat,
  input  logic                     mark,
  input  logic [ADDR_W-1:0]        mark_sel,
  output logic [DEPTH-1:0]         pending
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]    r_pending;
  logic [NWRITE-1:0]   w_wr_hit;
  logic [NWRITE-1:0]   w_wr_commit;
  logic                w_mark_ok;
  logic                w_start_clear;

  // An address names a real, writable entry (in range and not the hardwired zero).
  function automatic logic f_writable(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  assign busy    = (r_state == S_CLEAR);
  assign pending = r_pending;

  // A write hits for bypass purposes even on a clear-start edge, but only commits in plain IDLE.
  always_comb begin
    w_start_clear = (r_state == S_IDLE) && clear;
    w_mark_ok     = (r_state == S_IDLE) && !clear && mark && f_writable(mark_sel);
    for (int p = 0; p < NWRITE; p++) begin
      w_wr_hit[p]    = wen[p] && f_writable(wsel[p*ADDR_W +: ADDR_W]);
      w_wr_commit[p] = w_wr_hit[p] && (r_state == S_IDLE) && !clear;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clear) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_cnt == LAST) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (w_start_clear) begin
      r_cnt <= '0;
    end else if (busy) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Later ports are applied last, so the highest index wins on an address collision.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (busy) begin
      r_mem[r_cnt] <= '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        if (w_wr_commit[p]) begin
          r_mem[wsel[p*ADDR_W +: ADDR_W]] <= wdat[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Mark is applied after the write clears so a same-address new producer leaves the bit set.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_pending <= '0;
    end else if (w_start_clear) begin
      r_pending <= '0;
    end else if (!busy) begin
      for (int p = 0; p < NWRITE; p++) begin
        if (w_wr_commit[p]) begin
          r_pending[wsel[p*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (w_mark_ok) begin
        r_pending[mark_sel] <= 1'b1;
      end
    end
  end

  for (genvar r = 0; r < NREAD; r++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = rsel[r*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = '0;
      if (f_writable(w_addr)) begin
        w_data = r_mem[w_addr];
      end
      if (BYPASS && !busy) begin
        for (int p = 0; p < NWRITE; p++) begin
          if (w_wr_hit[p] && (wsel[p*ADDR_W +: ADDR_W] == w_addr)) begin
            w_data = wdat[p*DATA_W +: DATA_W];
          end
        end
      end
    end

    assign rdat[r*DATA_W +: DATA_W] = w_data;
  end

endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - scoreboard bench for param_register_file
// Two DUT copies share stimulus: one with bypass, one without.
module tb_param_register_file;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              clear;
  logic              mark;
  logic [AW-1:0]     mark_sel;
  logic [NW-1:0]     wen;
  logic [NW*AW-1:0]  wsel;
  logic [NW*DW-1:0]  wdat;
  logic [NR*AW-1:0]  rsel;
  logic              busy, busy_nb;
  logic [NR*DW-1:0]  rdat, rdat_nb;
  logic [DEPTH-1:0]  pending, pending_nb;

  always #5 CLK = ~CLK;

  param_register_file #(.DATA_W(DW), .DEPTH(DEPTH), .NREAD(NR), .NWRITE(NW),
                        .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .CLK(CLK), .nRST(nRST), .clear(clear), .busy(busy), .wen(wen), .wsel(wsel),
    .wdat(wdat), .rsel(rsel), .rdat(rdat), .mark(mark), .mark_sel(mark_sel),
    .pending(pending)
  );

  param_register_file #(.DATA_W(DW), .DEPTH(DEPTH), .NREAD(NR), .NWRITE(NW),
                        .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
    .CLK(CLK), .nRST(nRST), .clear(clear), .busy(busy_nb), .wen(wen), .wsel(wsel),
    .wdat(wdat), .rsel(rsel), .rdat(rdat_nb), .mark(mark), .mark_sel(mark_sel),
    .pending(pending_nb)
  );

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [31:0]      m_mem [DEPTH];
  logic [DEPTH-1:0] m_pend;
  int               m_clr_left;
  bit               m_valid = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      0: return "rdat_byp";
      1: return "rdat_nobyp";
      2: return "pending";
      3: return "busy";
      4: return "pending_nobyp";
      default: return "busy_nobyp";
    endcase
  endfunction

  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        0: act = rdat[e.idx*DW +: DW];
        1: act = rdat_nb[e.idx*DW +: DW];
        2: act = pending;
        3: act = {31'b0, busy};
        4: act = pending_nb;
        default: act = {31'b0, busy_nb};
      endcase
      n_tests++;
      if (e.cyc != cyc || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s cyc=%0d port=%0d got=%h exp=%h (checked at cyc %0d)",
                 kname(e.kind), e.cyc, e.idx, act, e.exp, cyc);
      end
    end
  end

  // Expected read value from the abstract model: array contents, zero rules, optional bypass.
  function automatic logic [31:0] m_read(int a, bit byp);
    logic [31:0] v;
    if (a == 0 || a >= DEPTH) return 32'h0;
    v = m_mem[a];
    if (byp && m_clr_left == 0) begin
      for (int p = 0; p < NW; p++) begin
        if (wen[p] && int'(wsel[p*AW +: AW]) == a) v = wdat[p*DW +: DW];
      end
    end
    return v;
  endfunction

  task automatic cycle();
    if (m_valid) begin
      for (int r = 0; r < NR; r++) begin
        int a;
        a = int'(rsel[r*AW +: AW]);
        sb.push_back('{cyc, 0, r, m_read(a, 1'b1)});
        sb.push_back('{cyc, 1, r, m_read(a, 1'b0)});
      end
      sb.push_back('{cyc, 2, 0, m_pend});
      sb.push_back('{cyc, 3, 0, 32'(m_clr_left > 0)});
      sb.push_back('{cyc, 4, 0, m_pend});
      sb.push_back('{cyc, 5, 0, 32'(m_clr_left > 0)});
    end
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      m_pend     = '0;
      m_clr_left = 0;
    end else if (m_clr_left > 0) begin
      m_mem[DEPTH - m_clr_left] = 32'h0;
      m_clr_left--;
    end else if (clear) begin
      m_clr_left = DEPTH;
      m_pend     = '0;
    end else begin
      for (int p = 0; p < NW; p++) begin
        int a;
        a = int'(wsel[p*AW +: AW]);
        if (wen[p] && a != 0) begin
          m_mem[a]  = wdat[p*DW +: DW];
          m_pend[a] = 1'b0;
        end
      end
      if (mark && mark_sel != 0) m_pend[mark_sel] = 1'b1;
    end
    m_valid = 1;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wen   = '0;
    mark  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic set_w(int p, int a, logic [31:0] d);
    wen[p]           = 1'b1;
    wsel[p*AW +: AW] = AW'(a);
    wdat[p*DW +: DW] = d;
  endtask

  task automatic set_r(int r, int a);
    rsel[r*AW +: AW] = AW'(a);
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
  endfunction

  task automatic rand_inputs(bit allow_clear);
    for (int p = 0; p < NW; p++) begin
      wen[p]           = $urandom_range(0, 1) == 1;
      wsel[p*AW +: AW] = AW'(rand_addr());
      wdat[p*DW +: DW] = $urandom;
    end
    for (int r = 0; r < NR; r++) begin
      if ($urandom_range(0, 1) == 1)
        rsel[r*AW +: AW] = wsel[$urandom_range(0, NW - 1)*AW +: AW];
      else
        rsel[r*AW +: AW] = AW'(rand_addr());
    end
    mark     = $urandom_range(0, 2) == 0;
    mark_sel = AW'(rand_addr());
    clear    = allow_clear && ($urandom_range(0, 39) == 0);
  endtask

  task automatic read_all();
    idle();
    for (int a = 0; a < DEPTH; a += 2) begin
      set_r(0, a);
      set_r(1, a + 1);
      cycle();
    end
  endtask

  initial begin
    nRST = 1'b0; clear = 1'b0; mark = 1'b0; mark_sel = '0;
    wen = '0; wsel = '0; wdat = '0; rsel = '0;
    cycle();
    cycle();
    nRST = 1'b1;
    read_all();

    idle(); set_w(0, 5, 32'hDEADBEEF); set_r(0, 5); set_r(1, 6);
    cycle();
    idle();
    cycle();

    idle(); set_w(0, 7, 32'hAAAA0000); set_w(1, 7, 32'hBBBB0000); set_r(0, 7); set_r(1, 5);
    cycle();
    idle();
    cycle();

    idle(); set_w(0, 0, 32'h12345678); set_r(0, 0); set_r(1, 7);
    cycle();
    idle();
    cycle();

    idle(); mark = 1'b1; mark_sel = 5'd3;
    cycle();
    idle();
    cycle();
    set_w(0, 3, 32'h33);
    cycle();
    idle();
    cycle();
    mark = 1'b1; mark_sel = 5'd9; set_w(1, 9, 32'h99);
    cycle();
    idle();
    cycle();

    for (int i = 0; i < 400; i++) begin
      rand_inputs(1'b0);
      cycle();
    end

    idle();
    for (int i = 1; i < DEPTH; i += 2) begin
      wen = '0;
      set_w(0, i, 32'(i));
      if (i + 1 < DEPTH) set_w(1, i + 1, 32'(i + 1));
      cycle();
    end
    idle(); mark = 1'b1; mark_sel = 5'd4;
    cycle();
    idle(); clear = 1'b1; set_w(0, 20, 32'hFFFF_FFFF); set_r(0, 1); set_r(1, 2);
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      rand_inputs(1'b0);
      clear = $urandom_range(0, 1) == 1;
      cycle();
    end
    read_all();

    for (int i = 0; i < 20; i++) begin
      rand_inputs(1'b0);
      cycle();
    end
    idle(); clear = 1'b1;
    cycle();
    for (int i = 0; i < 10; i++) begin
      rand_inputs(1'b0);
      cycle();
    end
    idle(); nRST = 1'b0;
    cycle();
    nRST = 1'b1; clear = 1'b1;
    cycle();
    for (int i = 0; i < DEPTH + 2; i++) begin
      rand_inputs(1'b0);
      clear = 1'b0;
      cycle();
    end
    read_all();

    for (int i = 0; i < 300; i++) begin
      rand_inputs(1'b1);
      cycle();
    end
    read_all();

    @(negedge CLK);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d leftover exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
